// File: rtl/ram_input_loader.sv
// Unpacks UART bytes LSB-first into single-bit writes of the input image RAM, addresses 0..NUM_BITS-1.
// Optional RAM_INPUT_LOADER_CHECKSUM_EN adds a trailing XOR check byte and the csum_err output.
module ram_input_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_BITS   = 784
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_vld,
    output logic                  rx_rdy,
    output logic                  ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
    ,
    output logic                  csum_err
`endif
);

    // One spare bit so the count of written bits can reach NUM_BITS == 2**ADDR_WIDTH.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_BITS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        UNPACK,
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
        CHECK,
`endif
        FINISH
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [7:0]      sreg;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_nxt;
    logic [CW-1:0]   cnt;
    logic            xfer;
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
    logic [7:0]      csum;
`endif

    assign xfer    = rx_vld && rx_rdy;
    assign bit_nxt = bit_idx + 3'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = WAIT_BYTE;
                end
            end
            WAIT_BYTE: begin
                if (xfer) begin
                    state_next = UNPACK;
                end
            end
            UNPACK: begin
                // cnt already counts the bit being written this cycle.
                if (cnt == LAST_CNT) begin
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
                    state_next = CHECK;
`else
                    state_next = FINISH;
`endif
                end else if (bit_idx == 3'd7) begin
                    state_next = WAIT_BYTE;
                end
            end
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
            CHECK: begin
                if (xfer) begin
                    state_next = FINISH;
                end
            end
`endif
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_rdy   <= 1'b0;
            ram_data <= 1'b0;
            ram_addr <= '0;
            ram_we   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sreg     <= '0;
            bit_idx  <= '0;
            cnt      <= '0;
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
            csum     <= '0;
            csum_err <= 1'b0;
`endif
        end else begin
            ram_we <= 1'b0;
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
            rx_rdy <= (state_next == WAIT_BYTE) || (state_next == CHECK);
            busy   <= (state_next == WAIT_BYTE) || (state_next == UNPACK) ||
                      (state_next == CHECK);
`else
            rx_rdy <= (state_next == WAIT_BYTE);
            busy   <= (state_next == WAIT_BYTE) || (state_next == UNPACK);
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        done <= 1'b0;
                        cnt  <= '0;
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
                        csum     <= '0;
                        csum_err <= 1'b0;
`endif
                    end
                end
                WAIT_BYTE: begin
                    if (xfer) begin
                        sreg     <= rx_data;
                        bit_idx  <= '0;
                        ram_we   <= 1'b1;
                        ram_data <= rx_data[0];
                        ram_addr <= cnt[ADDR_WIDTH-1:0];
                        cnt      <= cnt + 1'b1;
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
                        csum     <= csum ^ rx_data;
`endif
                    end
                end
                UNPACK: begin
                    if (state_next == UNPACK) begin
                        bit_idx  <= bit_nxt;
                        ram_we   <= 1'b1;
                        ram_data <= sreg[bit_nxt];
                        ram_addr <= cnt[ADDR_WIDTH-1:0];
                        cnt      <= cnt + 1'b1;
                    end
                end
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
                CHECK: begin
                    // Flag is valid alongside done so the reader sees both together.
                    if (xfer) begin
                        csum_err <= (rx_data != csum);
                    end
                end
`endif
                default: begin
                end
            endcase
            if (state_next == FINISH) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_input_loader.sv
// Directed bench for ram_input_loader: three (four with checksum) instances with different NUM_BITS.
module tb_ram_input_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_vld = 1'b0;
    int         sel = 2;

    always #5 clk = ~clk;

    logic       rdy8, data8, we8, busy8, done8;
    logic [9:0] addr8;
    logic       rdy10, data10, we10, busy10, done10;
    logic [9:0] addr10;
    logic       rdy_f, data_f, we_f, busy_f, done_f;
    logic [9:0] addr_f;
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
    logic       rdy16, data16, we16, busy16, done16, csum16;
    logic [9:0] addr16;
    logic       csum8, csum10, csum_f;
`endif

    ram_input_loader #(.ADDR_WIDTH(10), .NUM_BITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start && (sel == 0)), .rx_data(rx_data), .rx_vld(rx_vld),
        .rx_rdy(rdy8), .ram_data(data8), .ram_addr(addr8), .ram_we(we8), .busy(busy8), .done(done8)
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
        , .csum_err(csum8)
`endif
    );

    ram_input_loader #(.ADDR_WIDTH(10), .NUM_BITS(10)) dut10 (
        .clk(clk), .rst(rst), .start(start && (sel == 1)), .rx_data(rx_data), .rx_vld(rx_vld),
        .rx_rdy(rdy10), .ram_data(data10), .ram_addr(addr10), .ram_we(we10), .busy(busy10), .done(done10)
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
        , .csum_err(csum10)
`endif
    );

    ram_input_loader #(.ADDR_WIDTH(10), .NUM_BITS(784)) dut_f (
        .clk(clk), .rst(rst), .start(start && (sel == 2)), .rx_data(rx_data), .rx_vld(rx_vld),
        .rx_rdy(rdy_f), .ram_data(data_f), .ram_addr(addr_f), .ram_we(we_f), .busy(busy_f), .done(done_f)
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
        , .csum_err(csum_f)
`endif
    );

`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
    ram_input_loader #(.ADDR_WIDTH(10), .NUM_BITS(16)) dut16 (
        .clk(clk), .rst(rst), .start(start && (sel == 3)), .rx_data(rx_data), .rx_vld(rx_vld),
        .rx_rdy(rdy16), .ram_data(data16), .ram_addr(addr16), .ram_we(we16), .busy(busy16), .done(done16),
        .csum_err(csum16)
    );
`endif

    logic rdy_sel;
    always_comb begin
        rdy_sel = rdy_f;
        case (sel)
            0: rdy_sel = rdy8;
            1: rdy_sel = rdy10;
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
            3: rdy_sel = rdy16;
`endif
            default: rdy_sel = rdy_f;
        endcase
    end

    int   checks = 0;
    int   failures = 0;
    int   wcnt_f = 0;
    int   wcnt10 = 0;
    int   last10 = -1;
    int   hits_f [1024];
    logic mem_f  [1024];

    always @(negedge clk) begin
        if (we_f) begin
            mem_f[addr_f] = data_f;
            hits_f[addr_f] = hits_f[addr_f] + 1;
            wcnt_f = wcnt_f + 1;
        end
        if (we10) begin
            wcnt10 = wcnt10 + 1;
            last10 = int'(addr10);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; rx_vld = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Returns one cycle after the transfer edge, i.e. in the first write cycle.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data = b;
        rx_vld = 1'b1;
        while (rdy_sel !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 200) begin
            failures++;
            $display("FAIL send_timeout sel=%0d rx_rdy=%b required 1", sel, rdy_sel);
            rx_vld = 1'b0;
        end else begin
            tick();
            rx_vld = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rx_vld = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checks++;
        if (addr_f !== 10'd0 || data_f !== 1'b0) begin
            failures++;
            $display("FAIL reset_addr_data addr=%0d data=%b required 0/0", addr_f, data_f);
        end
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({rdy_f, we_f, busy_f, done_f, rdy8, we8, busy8, done8} !== 8'b0) begin
                failures++;
                $display("FAIL reset_idle cycle=%0d rdy/we/busy/done=%b%b%b%b required 0000",
                         c, rdy_f, we_f, busy_f, done_f);
            end
            tick();
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] b;
        b = 8'hA5;
        sel = 0;
        do_reset();
        pulse_start();
        checks++;
        if (busy8 !== 1'b1 || rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL single_wait busy=%b rdy=%b required 1/1", busy8, rdy8);
        end
        send_byte(b);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (we8 !== 1'b1 || addr8 !== 10'(i) || data8 !== b[i] || rdy8 !== 1'b0) begin
                failures++;
                $display("FAIL single_write bit=%0d we=%b addr=%0d data=%b rdy=%b required 1/%0d/%b/0",
                         i, we8, addr8, data8, rdy8, i, b[i]);
            end
            tick();
        end
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
        send_byte(8'hA5);
`endif
        checks++;
        if (done8 !== 1'b1 || we8 !== 1'b0 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL single_done done=%b we=%b busy=%b required 1/0/0", done8, we8, busy8);
        end
        tick(); tick(); tick();
        checks++;
        if (done8 !== 1'b1 || rdy8 !== 1'b0) begin
            failures++;
            $display("FAIL done_hold done=%b rdy=%b required 1/0", done8, rdy8);
        end
        pulse_start();
        checks++;
        if (done8 !== 1'b0 || busy8 !== 1'b1) begin
            failures++;
            $display("FAIL done_clear done=%b busy=%b required 0/1", done8, busy8);
        end
        do_reset();
    endtask

    task automatic test_full_image();
        logic [7:0] bytes [98];
        logic [7:0] x;
        int base, n, bad, exp_hits;
        sel = 2;
        do_reset();
        base = wcnt_f;
        x = 8'h00;
        pulse_start();
        for (int i = 0; i < 98; i++) begin
            bytes[i] = 8'($urandom);
            x = x ^ bytes[i];
            repeat ($urandom_range(0, 3)) tick();
            send_byte(bytes[i]);
        end
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
        send_byte(x);
`endif
        n = 0;
        while (done_f !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (done_f !== 1'b1) begin
            failures++;
            $display("FAIL full_done done=%b required 1", done_f);
        end
        checks++;
        if (wcnt_f - base !== 784) begin
            failures++;
            $display("FAIL full_we_count got=%0d required 784", wcnt_f - base);
        end
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            exp_hits = (a < 784) ? 1 : 0;
            if (hits_f[a] != exp_hits) bad++;
            else if (a < 784 && mem_f[a] !== bytes[a / 8][a % 8]) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL full_image bad_bits=%0d required 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b;
        a = 8'h3C;
        b = 8'hC3;
        sel = 2;
        do_reset();
        pulse_start();
        rx_data = a;
        rx_vld = 1'b1;
        tick();
        rx_data = b;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if (rdy_f !== 1'b0 || we_f !== 1'b1 || addr_f !== 10'(k - 1) || data_f !== a[k - 1]) begin
                failures++;
                $display("FAIL bp_hold cyc=T+%0d rdy=%b we=%b addr=%0d data=%b required 0/1/%0d/%b",
                         k, rdy_f, we_f, addr_f, data_f, k - 1, a[k - 1]);
            end
            tick();
        end
        checks++;
        if (rdy_f !== 1'b1 || we_f !== 1'b0) begin
            failures++;
            $display("FAIL bp_rdy_t9 rdy=%b we=%b required 1/0", rdy_f, we_f);
        end
        tick();
        rx_vld = 1'b0;
        checks++;
        if (we_f !== 1'b1 || addr_f !== 10'd8 || data_f !== b[0] || rdy_f !== 1'b0) begin
            failures++;
            $display("FAIL bp_second we=%b addr=%0d data=%b rdy=%b required 1/8/%b/0",
                     we_f, addr_f, data_f, rdy_f, b[0]);
        end
        do_reset();
    endtask

    task automatic test_partial_last();
        int base;
        sel = 1;
        do_reset();
        base = wcnt10;
        pulse_start();
        send_byte(8'hFF);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (we10 !== 1'b1 || addr10 !== 10'(i) || data10 !== 1'b1) begin
                failures++;
                $display("FAIL partial_b0 bit=%0d we=%b addr=%0d data=%b required 1/%0d/1",
                         i, we10, addr10, data10, i);
            end
            tick();
        end
        send_byte(8'h03);
        for (int i = 8; i < 10; i++) begin
            checks++;
            if (we10 !== 1'b1 || addr10 !== 10'(i) || data10 !== 1'b1) begin
                failures++;
                $display("FAIL partial_b1 bit=%0d we=%b addr=%0d data=%b required 1/%0d/1",
                         i, we10, addr10, data10, i);
            end
            tick();
        end
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
        send_byte(8'hFC);
`endif
        checks++;
        if (done10 !== 1'b1 || we10 !== 1'b0) begin
            failures++;
            $display("FAIL partial_done done=%b we=%b required 1/0", done10, we10);
        end
        tick(); tick();
        checks++;
        if (wcnt10 - base !== 10 || last10 !== 9) begin
            failures++;
            $display("FAIL partial_count writes=%0d last_addr=%0d required 10/9", wcnt10 - base, last10);
        end
    endtask

    task automatic test_midload_reset();
        int base;
        sel = 2;
        do_reset();
        pulse_start();
        for (int i = 0; i < 38; i++) begin
            send_byte(8'(i) ^ 8'h5A);
        end
        repeat (4) tick();
        checks++;
        if (we_f !== 1'b1 || addr_f !== 10'd300) begin
            failures++;
            $display("FAIL midrst_pre we=%b addr=%0d required 1/300", we_f, addr_f);
        end
        rst = 1'b1;
        tick();
        base = wcnt_f;
        checks++;
        if (we_f !== 1'b0 || busy_f !== 1'b0 || done_f !== 1'b0 || rdy_f !== 1'b0) begin
            failures++;
            $display("FAIL midrst_post we=%b busy=%b done=%b rdy=%b required 0/0/0/0",
                     we_f, busy_f, done_f, rdy_f);
        end
        rst = 1'b0;
        repeat (12) tick();
        checks++;
        if (wcnt_f - base !== 0 || busy_f !== 1'b0) begin
            failures++;
            $display("FAIL midrst_quiet writes=%0d busy=%b required 0/0", wcnt_f - base, busy_f);
        end
    endtask

`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        sel = 3;
        do_reset();
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h26);
        tick(); tick();
        checks++;
        if (done16 !== 1'b1 || csum16 !== 1'b0) begin
            failures++;
            $display("FAIL csum_good done=%b csum_err=%b required 1/0", done16, csum16);
        end
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h27);
        tick(); tick();
        checks++;
        if (done16 !== 1'b1 || csum16 !== 1'b1) begin
            failures++;
            $display("FAIL csum_bad done=%b csum_err=%b required 1/1", done16, csum16);
        end
        pulse_start();
        checks++;
        if (csum16 !== 1'b0 || done16 !== 1'b0) begin
            failures++;
            $display("FAIL csum_clear csum_err=%b done=%b required 0/0", csum16, done16);
        end
        do_reset();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_image();
        test_single_byte();
        test_back_to_back();
        test_partial_last();
        test_midload_reset();
`ifdef RAM_INPUT_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
